gsim_ctrl: RTL and testbench

GSIM_CTRL -- requirements
Module: gsim_ctrl

---
 rtl/gsim_pkg.sv | 16 +
 rtl/gsim_ctrl.sv | 105 ++++++++++
 tb/tb_gsim_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gsim_pkg.sv
// Shared sizes and state encoding for the Gauss-Seidel sweep sequencer.
package gsim_pkg;

    localparam int N     = 16;
    localparam int IDX_W = 4;
    localparam int SWP_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/gsim_ctrl.sv
// Sequencer for a 16x16 Gauss-Seidel solver: loads b, issues row
// updates for ITER sweeps, then streams x back out to the host.
module gsim_ctrl
    import gsim_pkg::*;
#(
    parameter int ITER = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    output logic             b_we,
    output logic [IDX_W-1:0] b_addr,
    output logic             x_clr,
    output logic             dp_start,
    output logic [IDX_W-1:0] dp_row,
    input  logic             dp_done,
    output logic             x_we,
    output logic             out_rd,
    output logic [IDX_W-1:0] out_addr,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST     = IDX_W'(N - 1);
    localparam logic [SWP_W-1:0] SWP_LAST = SWP_W'(ITER - 1);

    state_t           state_q;
    logic [IDX_W-1:0] ld_cnt_q;
    logic [IDX_W-1:0] row_q;
    logic [IDX_W-1:0] out_cnt_q;
    logic [SWP_W-1:0] swp_q;
    logic             out_valid_q;

    logic loading;
    logic waiting;

    assign loading = (state_q == IDLE) || (state_q == LOAD);
    assign waiting = (state_q == WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ld_cnt_q    <= '0;
            row_q       <= '0;
            out_cnt_q   <= '0;
            swp_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_q == OUT);
            unique case (state_q)
                IDLE, LOAD: begin
                    if (in_en) begin
                        ld_cnt_q <= ld_cnt_q + 1'b1;
                        if (ld_cnt_q == LAST) begin
                            state_q <= ISSUE;
                            row_q   <= '0;
                            swp_q   <= '0;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (dp_done) begin
                        if (row_q != LAST) begin
                            row_q   <= row_q + 1'b1;
                            state_q <= ISSUE;
                        end else if (swp_q != SWP_LAST) begin
                            row_q   <= '0;
                            swp_q   <= swp_q + 1'b1;
                            state_q <= ISSUE;
                        end else begin
                            state_q <= OUT;
                        end
                    end
                end
                OUT: begin
                    out_cnt_q <= out_cnt_q + 1'b1;
                    if (out_cnt_q == LAST) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // reset forces IDLE, where b_we would otherwise follow in_en
    assign b_we      = loading && in_en && reset;
    assign x_clr     = b_we;
    assign b_addr    = ld_cnt_q;
    assign dp_start  = (state_q == ISSUE);
    assign dp_row    = row_q;
    assign x_we      = waiting && dp_done;
    assign out_rd    = (state_q == OUT);
    assign out_addr  = out_cnt_q;
    assign out_valid = out_valid_q;
    assign busy      = !loading;

endmodule

// File: tb/tb_gsim_ctrl.sv
// Directed-plus-random bench for gsim_ctrl with a transaction-level
// model of the expected load / row-issue / readout sequence.
module tb_gsim_ctrl;
    import gsim_pkg::*;

    localparam int IT = 2;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       in_en   = 1'b0;
    logic       dp_done = 1'b0;
    logic       b_we;
    logic       x_clr;
    logic       dp_start;
    logic       x_we;
    logic       out_rd;
    logic       out_valid;
    logic       busy;
    logic [3:0] b_addr;
    logic [3:0] dp_row;
    logic [3:0] out_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gsim_ctrl #(.ITER(IT)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_en    (in_en),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .x_clr    (x_clr),
        .dp_start (dp_start),
        .dp_row   (dp_row),
        .dp_done  (dp_done),
        .x_we     (x_we),
        .out_rd   (out_rd),
        .out_addr (out_addr),
        .out_valid(out_valid),
        .busy     (busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic done);
        @(negedge clk);
        in_en   = en;
        dp_done = done;
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".b_we"},      32'(b_we),      32'd0);
        chk({tag, ".x_clr"},     32'(x_clr),     32'd0);
        chk({tag, ".dp_start"},  32'(dp_start),  32'd0);
        chk({tag, ".x_we"},      32'(x_we),      32'd0);
        chk({tag, ".out_rd"},    32'(out_rd),    32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".b_addr"},    32'(b_addr),    32'd0);
        chk({tag, ".dp_row"},    32'(dp_row),    32'd0);
        chk({tag, ".out_addr"},  32'(out_addr),  32'd0);
        chk({tag, ".state"},     32'(dut.state_q), 32'(IDLE));
    endtask

    function automatic logic rnd_bit(input int mode);
        return (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic do_abort();
        reset = 1'b0;
        in_en = 1'b1;
        #1;
        chk_quiet("abort");
        drive(1'b1, 1'b1);
        chk_quiet("abort_hold");
        @(negedge clk);
        reset   = 1'b1;
        in_en   = 1'b0;
        dp_done = 1'b1;
        #1;
        chk("late_done.x_we", 32'(x_we), 32'd0);
        drive(1'b0, 1'b0);
        chk("late_done.state", 32'(dut.state_q), 32'(IDLE));
        chk("late_done.busy", 32'(busy), 32'd0);
    endtask

    // mode 0: contiguous load, no noise
    // mode 1: 1,0,0,1 load pattern, noise on in_en/dp_done
    // mode 2: random load gaps, noise on in_en/dp_done
    task automatic run_problem(input int mode,
                               input int lat_fix,
                               input int abort_row);
        int   got = 0;
        int   cyc = 0;
        logic en;
        while (got < N && cyc < 2000) begin
            unique case (mode)
                0:       en = 1'b1;
                1:       en = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: en = 1'($urandom_range(0, 1));
            endcase
            drive(en, rnd_bit(mode));
            chk("load.b_we",     32'(b_we),     32'(en));
            chk("load.x_clr",    32'(x_clr),    32'(en));
            if (en) chk("load.b_addr", 32'(b_addr), 32'(got));
            chk("load.dp_start", 32'(dp_start), 32'd0);
            chk("load.x_we",     32'(x_we),     32'd0);
            chk("load.busy",     32'(busy),     32'd0);
            if (en) got++;
            cyc++;
        end
        chk("load.bound", 32'(got), 32'(N));

        for (int k = 0; k < N * IT; k++) begin
            int lat;
            lat = (lat_fix > 0) ? lat_fix
                                : int'($urandom_range(1, 4));
            drive(rnd_bit(mode), rnd_bit(mode));
            chk("issue.dp_start", 32'(dp_start), 32'd1);
            chk("issue.dp_row",   32'(dp_row),   32'(k % N));
            chk("issue.x_we",     32'(x_we),     32'd0);
            chk("issue.b_we",     32'(b_we),     32'd0);
            chk("issue.busy",     32'(busy),     32'd1);
            if (k == abort_row) begin
                drive(rnd_bit(mode), 1'b0);
                chk("abort.wait", 32'(dut.state_q), 32'(WAIT));
                chk("abort.row",  32'(dp_row), 32'(k % N));
                do_abort();
                return;
            end
            for (int c = 1; c <= lat; c++) begin
                logic d;
                d = (c == lat);
                drive(rnd_bit(mode), d);
                chk("wait.x_we",     32'(x_we),     32'(d));
                chk("wait.dp_start", 32'(dp_start), 32'd0);
                chk("wait.dp_row",   32'(dp_row),   32'(k % N));
                chk("wait.b_we",     32'(b_we),     32'd0);
                chk("wait.busy",     32'(busy),     32'd1);
            end
        end

        for (int i = 0; i <= N; i++) begin
            drive(1'b0, rnd_bit(mode));
            chk("out.rd",    32'(out_rd),    32'(i < N));
            if (i < N) chk("out.addr", 32'(out_addr), 32'(i));
            chk("out.valid", 32'(out_valid), 32'(i > 0));
            chk("out.busy",  32'(busy),      32'(i < N));
            chk("out.x_we",  32'(x_we),      32'd0);
            chk("out.start", 32'(dp_start),  32'd0);
        end
        drive(1'b0, 1'b0);
        chk("end.valid", 32'(out_valid), 32'd0);
        chk("end.busy",  32'(busy),      32'd0);
        chk("end.state", 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        #1;
        reset   = 1'b0;
        in_en   = 1'b1;
        dp_done = 1'b1;
        #1;
        chk_quiet("rst");
        drive(1'b1, 1'b1);
        chk_quiet("rst_hold");
        @(negedge clk);
        reset   = 1'b1;
        in_en   = 1'b0;
        dp_done = 1'b0;
        drive(1'b0, 1'b1);
        chk("idle.x_we", 32'(x_we), 32'd0);

        run_problem(0, 3, -1);
        run_problem(1, 0, -1);
        run_problem(2, 2, 7);
        run_problem(2, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
